// File: rtl/build_info_pkg.sv
// Shared definitions for the build-information AXI4-Lite responder:
// register offsets, response codes and FSM state types.
package build_info_pkg;

    localparam logic [4:0] OFF_SCRIPTS_LO = 5'h00;
    localparam logic [4:0] OFF_SCRIPTS_HI = 5'h04;
    localparam logic [4:0] OFF_TOP_LO     = 5'h08;
    localparam logic [4:0] OFF_TOP_HI     = 5'h0C;
    localparam logic [4:0] OFF_TS_SCRIPTS = 5'h10;
    localparam logic [4:0] OFF_TS_TOP     = 5'h14;
    localparam logic [4:0] OFF_ID         = 5'h18;
    localparam logic [4:0] OFF_SCRATCH    = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

endpackage

// File: rtl/build_info_axil_if.sv
// AXI4-Lite bus bundle used between the PS master and the build-info responder.
interface build_info_axil_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/build_info_axil.sv
// AXI4-Lite read responder for build-identification words with coherent 64-bit hash reads.
// Define BUILD_INFO_SCRATCH_EN to make offset 0x1C a byte-maskable R/W scratch register.
module build_info_axil
    import build_info_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'hB1D0_0001
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [63:0]       git_hash_scripts_i,
    input  logic [63:0]       git_hash_top_i,
    input  logic [31:0]       timestamp_scripts_i,
    input  logic [31:0]       timestamp_top_i,
    build_info_axil_if.slave  s_axil
);

    r_state_t    r_state_q, r_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] scripts_hi_q, scripts_hi_d;
    logic [31:0] top_hi_q, top_hi_d;

    w_state_t    w_state_q, w_state_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        ar_mapped;
    logic [4:0]  ar_off;
    logic        aw_hs, w_hs;
    logic        unused_ok;

    assign ar_mapped = ((s_axil.araddr >> 5) == '0);
    assign ar_off    = {s_axil.araddr[4:2], 2'b00};

    assign s_axil.arready = (r_state_q == R_IDLE);
    assign s_axil.rvalid  = (r_state_q == R_DATA);
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign s_axil.awready = (w_state_q == W_IDLE) && !aw_got_q;
    assign s_axil.wready  = (w_state_q == W_IDLE) && !w_got_q;
    assign s_axil.bvalid  = (w_state_q == W_RESP);
    assign s_axil.bresp   = bresp_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;

`ifdef BUILD_INFO_SCRATCH_EN
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [ADDR_W-1:0] aw_addr_eff;
    logic [31:0]       wdata_eff;
    logic [3:0]        wstrb_eff;

    // A channel that handshakes in the same cycle as its partner bypasses the holding register.
    assign aw_addr_eff = aw_got_q ? awaddr_q : s_axil.awaddr;
    assign wdata_eff   = w_got_q  ? wdata_q  : s_axil.wdata;
    assign wstrb_eff   = w_got_q  ? wstrb_q  : s_axil.wstrb;
    assign unused_ok   = ^{s_axil.araddr[1:0], s_axil.awaddr[1:0]};
`else
    assign unused_ok   = ^{s_axil.araddr[1:0], s_axil.awaddr, s_axil.wdata, s_axil.wstrb};
`endif

    always_comb begin
        r_state_d    = r_state_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        scripts_hi_d = scripts_hi_q;
        top_hi_d     = top_hi_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil.arvalid) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    if (!ar_mapped) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        case (ar_off)
                            OFF_SCRIPTS_LO: begin
                                rdata_d      = git_hash_scripts_i[31:0];
                                scripts_hi_d = git_hash_scripts_i[63:32];
                            end
                            OFF_SCRIPTS_HI: rdata_d = scripts_hi_q;
                            OFF_TOP_LO: begin
                                rdata_d  = git_hash_top_i[31:0];
                                top_hi_d = git_hash_top_i[63:32];
                            end
                            OFF_TOP_HI:     rdata_d = top_hi_q;
                            OFF_TS_SCRIPTS: rdata_d = timestamp_scripts_i;
                            OFF_TS_TOP:     rdata_d = timestamp_top_i;
                            OFF_ID:         rdata_d = ID_VALUE;
`ifdef BUILD_INFO_SCRATCH_EN
                            OFF_SCRATCH:    rdata_d = scratch_q;
`endif
                            default:        rresp_d = RESP_SLVERR;
                        endcase
                    end
                end
            end
            R_DATA: begin
                if (s_axil.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        bresp_d   = bresp_q;
`ifdef BUILD_INFO_SCRATCH_EN
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        scratch_d = scratch_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
`ifdef BUILD_INFO_SCRATCH_EN
                    awaddr_d = s_axil.awaddr;
`endif
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
`ifdef BUILD_INFO_SCRATCH_EN
                    wdata_d = s_axil.wdata;
                    wstrb_d = s_axil.wstrb;
`endif
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bresp_d   = RESP_SLVERR;
`ifdef BUILD_INFO_SCRATCH_EN
                    if (((aw_addr_eff >> 5) == '0) && (aw_addr_eff[4:2] == OFF_SCRATCH[4:2])) begin
                        bresp_d = RESP_OKAY;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_eff[b]) begin
                                scratch_d[8*b +: 8] = wdata_eff[8*b +: 8];
                            end
                        end
                    end
`endif
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            r_state_q    <= R_IDLE;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            scripts_hi_q <= '0;
            top_hi_q     <= '0;
            w_state_q    <= W_IDLE;
            aw_got_q     <= 1'b0;
            w_got_q      <= 1'b0;
            bresp_q      <= RESP_OKAY;
`ifdef BUILD_INFO_SCRATCH_EN
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            scratch_q    <= '0;
`endif
        end else begin
            r_state_q    <= r_state_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            scripts_hi_q <= scripts_hi_d;
            top_hi_q     <= top_hi_d;
            w_state_q    <= w_state_d;
            aw_got_q     <= aw_got_d;
            w_got_q      <= w_got_d;
            bresp_q      <= bresp_d;
`ifdef BUILD_INFO_SCRATCH_EN
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            scratch_q    <= scratch_d;
`endif
        end
    end

endmodule

// File: tb/tb_build_info_axil.sv
// Scoreboard bench for build_info_axil: stimulus queues expected responses, a monitor checks them.
module tb_build_info_axil;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

`ifdef BUILD_INFO_SCRATCH_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic        clk100;
    logic        rst;
    logic [63:0] git_hash_scripts_i;
    logic [63:0] git_hash_top_i;
    logic [31:0] timestamp_scripts_i;
    logic [31:0] timestamp_top_i;

    build_info_axil_if #(.ADDR_W(8)) s_axil ();

    build_info_axil #(.ADDR_W(8), .ID_VALUE(32'hB1D0_0001)) dut (
        .clk100              (clk100),
        .rst                 (rst),
        .git_hash_scripts_i  (git_hash_scripts_i),
        .git_hash_top_i      (git_hash_top_i),
        .timestamp_scripts_i (timestamp_scripts_i),
        .timestamp_top_i     (timestamp_top_i),
        .s_axil              (s_axil)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] rq[$];
    logic [1:0]  bq[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // Monitor: compares every accepted R and B beat against the head of its queue.
    initial begin
        logic [33:0] er;
        logic [1:0]  eb;
        forever begin
            @(negedge clk100);
            if (!rst && s_axil.rvalid && s_axil.rready) begin
                if (rq.size() == 0) begin
                    check_bit("r_unexpected", 1'b1, 1'b0);
                end else begin
                    er = rq.pop_front();
                    $display("[TB] R data=%h resp=%0d (exp %h/%0d)", s_axil.rdata, s_axil.rresp, er[31:0], er[33:32]);
                    check("rdata", s_axil.rdata, er[31:0]);
                    check("rresp", {30'b0, s_axil.rresp}, {30'b0, er[33:32]});
                end
            end
            if (!rst && s_axil.bvalid && s_axil.bready) begin
                if (bq.size() == 0) begin
                    check_bit("b_unexpected", 1'b1, 1'b0);
                end else begin
                    eb = bq.pop_front();
                    $display("[TB] B resp=%0d (exp %0d)", s_axil.bresp, eb);
                    check("bresp", {30'b0, s_axil.bresp}, {30'b0, eb});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] resp);
        int n;
        rq.push_back({resp, d});
        tick();
        s_axil.araddr  = a;
        s_axil.arvalid = 1'b1;
        n = 0;
        while (!s_axil.arready && n < 20) begin tick(); n++; end
        check_bit("ar_wait", s_axil.arready, 1'b1);
        tick();
        s_axil.arvalid = 1'b0;
        check_bit("ar_to_rvalid_lat1", s_axil.rvalid, 1'b1);
        check_bit("arready_low_in_rdata", s_axil.arready, 1'b0);
        n = 0;
        while (s_axil.rvalid && n < 20) begin tick(); n++; end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit w_first, input logic [1:0] resp);
        bq.push_back(resp);
        tick();
        if (w_first) begin
            s_axil.wdata = d; s_axil.wstrb = s; s_axil.wvalid = 1'b1;
        end else begin
            s_axil.awaddr = a; s_axil.awvalid = 1'b1;
        end
        tick();
        if (w_first) begin
            s_axil.wvalid = 1'b0;
            check_bit("wready_drop", s_axil.wready, 1'b0);
            check_bit("awready_kept", s_axil.awready, 1'b1);
            s_axil.awaddr = a; s_axil.awvalid = 1'b1;
        end else begin
            s_axil.awvalid = 1'b0;
            check_bit("awready_drop", s_axil.awready, 1'b0);
            check_bit("wready_kept", s_axil.wready, 1'b1);
            s_axil.wdata = d; s_axil.wstrb = s; s_axil.wvalid = 1'b1;
        end
        tick();
        s_axil.awvalid = 1'b0;
        s_axil.wvalid  = 1'b0;
        check_bit("bvalid_after_both", s_axil.bvalid, 1'b1);
        tick();
        check_bit("bvalid_done", s_axil.bvalid, 1'b0);
        check_bit("readies_back", s_axil.awready && s_axil.wready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        git_hash_scripts_i  = 64'h0123_4567_89AB_CDEF;
        git_hash_top_i      = 64'hAABB_CCDD_1122_3344;
        timestamp_scripts_i = 32'h6500_1234;
        timestamp_top_i     = 32'h6500_5678;
        s_axil.awaddr = '0; s_axil.awvalid = 1'b0;
        s_axil.wdata = '0;  s_axil.wstrb = '0; s_axil.wvalid = 1'b0;
        s_axil.bready = 1'b1;
        s_axil.araddr = '0; s_axil.arvalid = 1'b0;
        s_axil.rready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_bit("rst_arready", s_axil.arready, 1'b1);
        check_bit("rst_awready", s_axil.awready, 1'b1);
        check_bit("rst_wready",  s_axil.wready,  1'b1);
        check_bit("rst_rvalid",  s_axil.rvalid,  1'b0);
        check_bit("rst_bvalid",  s_axil.bvalid,  1'b0);
        check("rst_rdata", s_axil.rdata, 32'h0);
        check("rst_resps", {28'b0, s_axil.rresp, s_axil.bresp}, 32'h0);

        do_read(8'h0C, 32'h0000_0000, OKAY);
        do_read(8'h18, 32'hB1D0_0001, OKAY);
        do_read(8'h20, 32'h0000_0000, SLVERR);
        do_read(8'h00, 32'h89AB_CDEF, OKAY);
        git_hash_scripts_i = 64'hFFFF_FFFF_0000_0000;
        do_read(8'h04, 32'h0123_4567, OKAY);
        do_read(8'h08, 32'h1122_3344, OKAY);
        do_read(8'h0C, 32'hAABB_CCDD, OKAY);
        do_read(8'h10, 32'h6500_1234, OKAY);
        do_read(8'h14, 32'h6500_5678, OKAY);

        // Backpressure: rready low for 5 cycles while a second AR waits.
        rq.push_back({OKAY, 32'hB1D0_0001});
        rq.push_back({OKAY, 32'h6500_1234});
        s_axil.rready = 1'b0;
        s_axil.araddr = 8'h18; s_axil.arvalid = 1'b1;
        tick();
        s_axil.araddr = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit("hold_rvalid", s_axil.rvalid, 1'b1);
            check("hold_rdata", s_axil.rdata, 32'hB1D0_0001);
            check_bit("hold_arready", s_axil.arready, 1'b0);
        end
        s_axil.rready = 1'b1;
        tick();
        check_bit("idle_gap_rvalid", s_axil.rvalid, 1'b0);
        tick();
        s_axil.arvalid = 1'b0;
        check_bit("second_ar_rvalid", s_axil.rvalid, 1'b1);
        tick();

        do_write(8'h1C, 32'hDEAD_BEEF, 4'b0011, 1'b1, SCR ? OKAY : SLVERR);
        do_read(8'h1C, SCR ? 32'h0000_BEEF : 32'h0, SCR ? OKAY : SLVERR);
        do_write(8'h1C, 32'h1234_5678, 4'b1100, 1'b0, SCR ? OKAY : SLVERR);
        do_read(8'h1C, SCR ? 32'h1234_BEEF : 32'h0, SCR ? OKAY : SLVERR);
        do_write(8'h10, 32'hFFFF_FFFF, 4'b1111, 1'b0, SLVERR);
        do_read(8'h10, 32'h6500_1234, OKAY);

        // Same-cycle read and write of scratch: read must see the old value.
        rq.push_back({SCR ? OKAY : SLVERR, SCR ? 32'h1234_BEEF : 32'h0});
        bq.push_back(SCR ? OKAY : SLVERR);
        s_axil.araddr = 8'h1C; s_axil.arvalid = 1'b1;
        s_axil.awaddr = 8'h1C; s_axil.awvalid = 1'b1;
        s_axil.wdata = 32'hCAFE_F00D; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
        tick();
        s_axil.arvalid = 1'b0; s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
        check_bit("simul_rvalid", s_axil.rvalid, 1'b1);
        check_bit("simul_bvalid", s_axil.bvalid, 1'b1);
        tick();
        do_read(8'h1C, SCR ? 32'hCAFE_F00D : 32'h0, SCR ? OKAY : SLVERR);

        // Reset while both responses are pending; these transactions are discarded.
        s_axil.rready = 1'b0; s_axil.bready = 1'b0;
        s_axil.araddr = 8'h18; s_axil.arvalid = 1'b1;
        s_axil.awaddr = 8'h1C; s_axil.awvalid = 1'b1;
        s_axil.wdata = 32'h5555_5555; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
        tick();
        s_axil.arvalid = 1'b0; s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
        tick();
        check_bit("pre_rst_rvalid", s_axil.rvalid, 1'b1);
        check_bit("pre_rst_bvalid", s_axil.bvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("async_rst_rvalid", s_axil.rvalid, 1'b0);
        check_bit("async_rst_bvalid", s_axil.bvalid, 1'b0);
        tick();
        rst = 1'b0;
        s_axil.rready = 1'b1; s_axil.bready = 1'b1;
        tick();
        check_bit("post_rst_arready", s_axil.arready, 1'b1);
        do_read(8'h1C, 32'h0, SCR ? OKAY : SLVERR);
        do_read(8'h04, 32'h0, OKAY);

        repeat (3) tick();
        check("rq_drained", rq.size(), 32'd0);
        check("bq_drained", bq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
